// File: rtl/mem_burst_pkg.sv
// Shared types for the memory burst splitter: FSM state encoding and the
// per-request tag that travels from issue to response.
package mem_burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Tag stored per granted beat: marks the final beat of its burst.
    typedef logic tag_t;

endpackage

// File: rtl/mem_burst_rsp_buffer.sv
// Response side of the burst splitter. Tracks outstanding beats with an
// in-order tag FIFO, captures memory responses into a buffer that can be
// back-pressured, and reports whether another beat may be issued.
module mem_burst_rsp_buffer
    import mem_burst_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int UserWidth = 1,
    parameter int MaxTrans  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 grant_i,
    input  tag_t                 last_i,
    input  logic                 rvalid_i,
    input  logic [DataWidth-1:0] rdata_i,
    input  logic [UserWidth-1:0] ruser_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic [UserWidth-1:0] rsp_user_o,
    output logic                 rsp_last_o,
    output logic                 credit_o
);

    localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int CntW = $clog2(MaxTrans + 1);
    localparam int EntW = DataWidth + UserWidth + 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);
    localparam logic [CntW:0]   MaxCnt  = (CntW + 1)'(MaxTrans);

    tag_t            tag_mem [MaxTrans];
    logic [PtrW-1:0] tag_wr_q;
    logic [PtrW-1:0] tag_rd_q;
    logic [CntW-1:0] outstanding_q;

    logic [EntW-1:0] rsp_mem [MaxTrans];
    logic [PtrW-1:0] rsp_wr_q;
    logic [PtrW-1:0] rsp_rd_q;
    logic [CntW-1:0] rsp_cnt_q;

    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Issued-but-unanswered beats plus buffered responses never exceed the
    // buffer depth, so an rvalid can always be stored.
    assign credit_o    = ({1'b0, outstanding_q} + {1'b0, rsp_cnt_q}) < MaxCnt;
    assign rsp_valid_o = (rsp_cnt_q != '0);
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign {rsp_data_o, rsp_user_o, rsp_last_o} = rsp_mem[rsp_rd_q];

    // Pointers and occupancy counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            rsp_wr_q      <= '0;
            rsp_rd_q      <= '0;
            outstanding_q <= '0;
            rsp_cnt_q     <= '0;
        end else begin
            if (grant_i) tag_wr_q <= ptr_inc(tag_wr_q);
            if (rvalid_i) begin
                tag_rd_q <= ptr_inc(tag_rd_q);
                rsp_wr_q <= ptr_inc(rsp_wr_q);
            end
            if (pop) rsp_rd_q <= ptr_inc(rsp_rd_q);

            case ({grant_i, rvalid_i})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase

            case ({rvalid_i, pop})
                2'b10:   rsp_cnt_q <= rsp_cnt_q + 1'b1;
                2'b01:   rsp_cnt_q <= rsp_cnt_q - 1'b1;
                default: rsp_cnt_q <= rsp_cnt_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk_i) begin
        if (grant_i)  tag_mem[tag_wr_q] <= last_i;
        if (rvalid_i) rsp_mem[rsp_wr_q] <= {rdata_i, ruser_i, tag_mem[tag_rd_q]};
    end

    // A response with nothing outstanding means the memory side misbehaved
    always_ff @(posedge clk_i) begin
        if (!rst_i && rvalid_i) begin
            assert (outstanding_q != '0)
                else $error("mem_burst_rsp_buffer: rvalid_i with no outstanding request");
        end
    end

endmodule

// File: rtl/mem_burst_splitter.sv
// Splits burst commands into one aligned, full-width req/gnt memory access
// per beat and returns the in-order responses with a per-burst last flag.
module mem_burst_splitter
    import mem_burst_pkg::*;
#(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int WUserWidth = 1,
    parameter int RUserWidth = 1,
    parameter int NumBanks   = 1,
    parameter int LenWidth   = 8,
    parameter int MaxTrans   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [AddrWidth-1:0]           cmd_addr_i,
    input  logic [LenWidth-1:0]            cmd_len_i,
    input  logic                           cmd_we_i,
    input  logic [WUserWidth-1:0]          cmd_wuser_i,
    input  logic                           wdat_valid_i,
    output logic                           wdat_ready_o,
    input  logic [DataWidth-1:0]           wdat_data_i,
    input  logic [DataWidth/8-1:0]         wdat_strb_i,
    output logic                           req_o,
    input  logic                           gnt_i,
    output logic [AddrWidth-1:0]           addr_o,
    output logic [DataWidth-1:0]           wdata_o,
    output logic [DataWidth/8-1:0]         strb_o,
    output logic [WUserWidth-1:0]          wuser_o,
    output logic                           we_o,
    input  logic                           rvalid_i,
    input  logic [DataWidth-1:0]           rdata_i,
    input  logic [NumBanks*RUserWidth-1:0] ruser_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DataWidth-1:0]           rsp_data_o,
    output logic [NumBanks*RUserWidth-1:0] rsp_user_o,
    output logic                           rsp_last_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam logic [AddrWidth-1:0] BeatBytes = AddrWidth'(StrbWidth);

    state_e                state_q;
    state_e                state_d;
    logic [AddrWidth-1:0]  addr_q;
    logic [LenWidth-1:0]   len_q;
    logic [LenWidth-1:0]   beat_q;
    logic                  we_q;
    logic [WUserWidth-1:0] wuser_q;
    logic                  credit;
    logic                  grant;
    logic                  last_beat;
    logic                  cmd_take;

    assign cmd_take  = (state_q == IDLE) & cmd_valid_i;
    assign last_beat = (beat_q == len_q);
    assign grant     = req_o & gnt_i;

    // Beat payload: address and sideband from the latched burst, write data
    // straight from the write stream so a stalled beat follows its source.
    assign addr_o  = addr_q;
    assign wdata_o = we_q ? wdat_data_i : '0;
    assign strb_o  = we_q ? wdat_strb_i : '1;
    assign wuser_o = wuser_q;
    assign we_o    = we_q;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs; a burst ends on the grant of its last beat
    always_comb begin
        state_d      = state_q;
        cmd_ready_o  = 1'b0;
        req_o        = 1'b0;
        wdat_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = ISSUE;
            end
            ISSUE: begin
                req_o        = credit & (~we_q | wdat_valid_i);
                wdat_ready_o = we_q & credit & gnt_i;
                if (credit & (~we_q | wdat_valid_i) & gnt_i & last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat counter: cleared per burst, advanced per grant
    always_ff @(posedge clk_i) begin
        if (rst_i)         beat_q <= '0;
        else if (cmd_take) beat_q <= '0;
        else if (grant)    beat_q <= beat_q + 1'b1;
    end

    // Burst context: latched on command accept, address stepped per grant
    always_ff @(posedge clk_i) begin
        if (cmd_take) begin
            addr_q  <= cmd_addr_i & ~(BeatBytes - 1'b1);
            len_q   <= cmd_len_i;
            we_q    <= cmd_we_i;
            wuser_q <= cmd_wuser_i;
        end else if (grant) begin
            addr_q  <= addr_q + BeatBytes;
        end
    end

    mem_burst_rsp_buffer #(
        .DataWidth (DataWidth),
        .UserWidth (NumBanks * RUserWidth),
        .MaxTrans  (MaxTrans)
    ) u_rsp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .grant_i     (grant),
        .last_i      (last_beat),
        .rvalid_i    (rvalid_i),
        .rdata_i     (rdata_i),
        .ruser_i     (ruser_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_user_o  (rsp_user_o),
        .rsp_last_o  (rsp_last_o),
        .credit_o    (credit)
    );

endmodule
